// File: rtl/decay_sweep_scheduler.sv
// Time-multiplexed LIF potential-decay sweep over NUM_NEURONS neurons with a shared-adder handshake.
// Optional: DECAY_SCHED_SKIP_UNITY_EN skips the write-back of divide-by-1 neurons.
module decay_sweep_scheduler #(
  parameter int NUM_NEURONS = 30,
  parameter int ADDR_W      = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [15:0]       sweep_count,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_potential,
  input  logic [3:0]        rd_rate,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              add_req,
  output logic [31:0]       add_a,
  output logic [31:0]       add_b,
  input  logic              add_ack,
  input  logic [31:0]       add_result
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EVAL, S_ADD, S_WRITE, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_NEURONS - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        k;
  logic              is_add;

  // Exponent-shift divide by 2^k; Inf/NaN pass through, underflow flushes to +0.
  function automatic logic [31:0] decay(input logic [31:0] x, input logic [1:0] sh);
    if (x[30:23] == 8'hFF || sh == 2'd0) return x;
    if (x[30:23] <= {6'd0, sh}) return 32'h0000_0000;
    return {x[31], x[30:23] - {6'd0, sh}, x[22:0]};
  endfunction

  always_comb begin
    k      = 2'd0;
    is_add = 1'b0;
    case (rd_rate)
      4'b0010: k = 2'd1;
      4'b0100: k = 2'd2;
      4'b1000: k = 2'd3;
      4'b0011: is_add = 1'b1;
      default: k = 2'd0;
    endcase
  end

  assign rd_addr = idx;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sweep_count <= 16'd0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= 32'd0;
      add_req     <= 1'b0;
      add_a       <= 32'd0;
      add_b       <= 32'd0;
    end else begin
      done  <= 1'b0;
      wr_en <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          idx   <= '0;
          busy  <= 1'b1;
          state <= S_FETCH;
        end
        S_FETCH: state <= S_EVAL;
        S_EVAL: begin
          if (is_add) begin
            add_req <= 1'b1;
            add_a   <= decay(rd_potential, 2'd1);
            add_b   <= decay(rd_potential, 2'd2);
            state   <= S_ADD;
          end
`ifdef DECAY_SCHED_SKIP_UNITY_EN
          else if (k == 2'd0) begin
            // Unchanged value: no write-back, move straight on.
            if (idx == LAST) begin
              done        <= 1'b1;
              busy        <= 1'b0;
              sweep_count <= sweep_count + 16'd1;
              state       <= S_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_FETCH;
            end
          end
`endif
          else begin
            wr_en   <= 1'b1;
            wr_addr <= idx;
            wr_data <= decay(rd_potential, k);
            state   <= S_WRITE;
          end
        end
        S_ADD: if (add_ack) begin
          add_req <= 1'b0;
          wr_en   <= 1'b1;
          wr_addr <= idx;
          wr_data <= add_result;
          state   <= S_WRITE;
        end
        S_WRITE: begin
          if (idx == LAST) begin
            done        <= 1'b1;
            busy        <= 1'b0;
            sweep_count <= sweep_count + 16'd1;
            state       <= S_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_FETCH;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decay_sweep_scheduler.sv
// Directed bench for decay_sweep_scheduler: memory model, adder responder, sweep timing and reset.
module tb_decay_sweep_scheduler;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic        busy, done, wr_en, add_req;
  logic [15:0] sweep_count;
  logic [4:0]  rd_addr, wr_addr;
  logic [31:0] rd_potential, wr_data, add_a, add_b, add_result;
  logic [3:0]  rd_rate;
  logic        add_ack;

  decay_sweep_scheduler dut (
    .CLK(CLK), .RST(RST), .start(start), .busy(busy), .done(done),
    .sweep_count(sweep_count), .rd_addr(rd_addr), .rd_potential(rd_potential),
    .rd_rate(rd_rate), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .add_req(add_req), .add_a(add_a), .add_b(add_b), .add_ack(add_ack),
    .add_result(add_result)
  );

  always #5 CLK = ~CLK;

  logic [31:0] pot  [32];
  logic [3:0]  rate [32];

  // One-cycle-latency state memory.
  always @(posedge CLK) begin
    rd_potential <= pot[rd_addr];
    rd_rate      <= rate[rd_addr];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got_v, exp_v);
    end
  endtask

  int          done_at, nwr, busy_cnt, order_err, extra_evt, first_wa;
  logic        busy_at_done;
  logic [31:0] got [32];
  logic [31:0] cap_a, cap_b;

  task automatic fill(input logic [31:0] v, input logic [3:0] r);
    for (int i = 0; i < 32; i++) begin
      pot[i]  = v;
      rate[i] = r;
    end
  endtask

  // Pulses start, then samples each cycle at the falling edge (sample n = state after edge n-1).
  task automatic sweep(input int ack_delay, input int restart_at, input logic [31:0] ack_val);
    int  last, wait_n;
    bit  saw_add;
    done_at = 0; nwr = 0; busy_cnt = 0; order_err = 0; extra_evt = 0;
    first_wa = -1; last = -1; wait_n = 0; saw_add = 0; busy_at_done = 1'b1;
    cap_a = 32'hX; cap_b = 32'hX;
    for (int i = 0; i < 32; i++) got[i] = 32'hDEAD_BEEF;
    @(negedge CLK); start = 1'b1;
    @(negedge CLK);
    for (int n = 1; n <= 400; n++) begin
      if (n > 1) @(negedge CLK);
      start   = (n == restart_at);
      add_ack = 1'b0;
      if (busy) busy_cnt++;
      if (wr_en) begin
        nwr++;
        if (first_wa < 0) first_wa = int'(wr_addr);
        if (int'(wr_addr) <= last) order_err++;
        last = int'(wr_addr);
        got[wr_addr] = wr_data;
      end
      if (add_req) begin
        if (!saw_add) begin
          cap_a = add_a; cap_b = add_b; saw_add = 1;
        end
        wait_n++;
        if (wait_n > ack_delay) begin
          add_ack = 1'b1; add_result = ack_val; wait_n = 0;
        end
      end
      if (done) begin
        done_at = n; busy_at_done = busy;
        break;
      end
    end
    start = 1'b0; add_ack = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      if (done || wr_en) extra_evt++;
    end
  endtask

  initial begin
    int bad, wr_cnt;
    RST = 1'b1; start = 1'b0; add_ack = 1'b0; add_result = 32'd0;
    fill(32'h41DED852, 4'b0010);
    repeat (3) @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", sweep_count, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_add_req", add_req, 0);
    chk("rst_rd_addr", rd_addr, 0);
    RST = 1'b0;

    // Uniform divide-by-2 sweep.
    sweep(0, 0, 32'd0);
    chk("a_nwr", nwr, 30);
    chk("a_order", order_err, 0);
    chk("a_first", first_wa, 0);
    chk("a_done_at", done_at, 91);
    chk("a_busy_cnt", busy_cnt, 90);
    chk("a_busy_done", busy_at_done, 0);
    chk("a_count", sweep_count, 1);
    bad = 0;
    for (int i = 0; i < 30; i++) if (got[i] !== 32'h415ED852) bad++;
    chk("a_data", bad, 0);
    chk("a_extra", extra_evt, 0);

    // Mixed rates: /8, underflow flush, Inf, shared adder, unknown code.
    fill(32'h41DED852, 4'b0010);
    pot[1] = 32'h01800000; pot[2] = 32'h7F800000; pot[4] = 32'h3F800000;
    rate[0] = 4'b1000; rate[1] = 4'b1000; rate[2] = 4'b0100;
    rate[3] = 4'b0011; rate[4] = 4'b0110;
    sweep(5, 0, 32'h12345678);
    chk("b_div8", got[0], 32'h405ED852);
    chk("b_flush", got[1], 32'h00000000);
    chk("b_inf", got[2], 32'h7F800000);
    chk("b_add_a", cap_a, 32'h415ED852);
    chk("b_add_b", cap_b, 32'h40DED852);
    chk("b_add_res", got[3], 32'h12345678);
    chk("b_div2", got[29], 32'h415ED852);
    chk("b_order", order_err, 0);
`ifdef DECAY_SCHED_SKIP_UNITY_EN
    chk("b_unknown", got[4], 32'hDEAD_BEEF);
    chk("b_nwr", nwr, 29);
    chk("b_done_at", done_at, 96);
`else
    chk("b_unknown", got[4], 32'h3F800000);
    chk("b_nwr", nwr, 30);
    chk("b_done_at", done_at, 97);
`endif
    chk("b_count", sweep_count, 2);

    // Second start mid-sweep is ignored.
    fill(32'h41DED852, 4'b0010);
    sweep(0, 20, 32'd0);
    chk("c_nwr", nwr, 30);
    chk("c_done_at", done_at, 91);
    chk("c_extra", extra_evt, 0);
    chk("c_count", sweep_count, 3);

    // All divide-by-1.
    fill(32'h41DED852, 4'b0001);
    sweep(0, 0, 32'd0);
`ifdef DECAY_SCHED_SKIP_UNITY_EN
    chk("d_nwr", nwr, 0);
    chk("d_done_at", done_at, 61);
`else
    chk("d_nwr", nwr, 30);
    chk("d_done_at", done_at, 91);
    chk("d_data", got[7], 32'h41DED852);
`endif
    chk("d_count", sweep_count, 4);

    // Asynchronous reset mid-sweep, then a clean sweep.
    fill(32'h41DED852, 4'b0010);
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    repeat (39) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("r_busy", busy, 0);
    chk("r_wr_en", wr_en, 0);
    chk("r_count", sweep_count, 0);
    chk("r_rd_addr", rd_addr, 0);
    chk("r_wr_data", wr_data, 0);
    wr_cnt = 0;
    repeat (5) begin
      @(negedge CLK);
      if (wr_en || done) wr_cnt++;
    end
    chk("r_quiet", wr_cnt, 0);
    RST = 1'b0;
    sweep(0, 0, 32'd0);
    chk("r2_first", first_wa, 0);
    chk("r2_nwr", nwr, 30);
    chk("r2_done_at", done_at, 91);
    chk("r2_count", sweep_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
